mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Initiator-side controller for the team's single-port-pair memory, which has a registered read and swaps the two halves of data written to upper-half addresses. The controller accepts host read/write requests on a valid/ready interface and drives the memory's write/read strobes, data and addresses. It never asserts a write and a read in the same cycle. It un-swaps upper-half read data, so a host write followed by a read of the same address returns the original value.

Parameters:
WIDTH, 2, data width in bits; must be even (halves are swapped).
PSIZE, 2, address width in bits.
DEPTH, 2**PSIZE, number of memory words; addresses >= DEPTH/2 form the "upper half".

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request valid
req_ready  output  1  controller can accept a request
req_wr  input  1  1 = write, 0 = read
req_addr  input  PSIZE  request address
req_wdata  input  WIDTH  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  host accepts read data
rsp_rdata  output  WIDTH  read data, un-swapped to original order
mem_wr  output  1  memory write strobe
mem_rd  output  1  memory read strobe
mem_wdata  output  WIDTH  memory write data
mem_wr_addr  output  PSIZE  memory write address
mem_rd_addr  output  PSIZE  memory read address
mem_rdata  input  WIDTH  memory registered read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Registered outputs: all outputs are registered except req_ready and busy, which decode the state register.
- Reset values: state=IDLE; mem_wr=0, mem_rd=0; mem_wdata, mem_wr_addr, mem_rd_addr, rsp_rdata all 0; rsp_valid=0.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. A read transfer completes when rsp_valid && rsp_ready.
- FSM states: IDLE, WR, RD, CAP, RESP.
- IDLE: on accept, latch req_addr and req_wdata.
  - Write: next state WR; mem_wr=1, mem_wr_addr=addr, mem_wdata=req_wdata (raw, no swap; the memory swaps upper-half writes itself).
  - Read: next state RD; mem_rd=1, mem_rd_addr=addr.
- WR: mem_wr is high for exactly this one cycle, then cleared. Next state is IDLE. Write occupancy is 2 cycles (accept + WR); no response is generated.
- RD: mem_rd is high for exactly this one cycle. The memory registers out_data at the end of this cycle. Next state is CAP.
- CAP: sample mem_rdata. If addr < DEPTH/2, rsp_rdata = mem_rdata. Otherwise rsp_rdata = {mem_rdata[WIDTH/2-1:0], mem_rdata[WIDTH-1:WIDTH/2]}. Set rsp_valid=1. Next state is RESP.
- RESP: hold rsp_valid and rsp_rdata stable until rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE.
  - Minimum read latency is 3 cycles from accept to rsp_valid; occupancy is 4 cycles with rsp_ready tied high.
  - No new request is accepted until the response is consumed.
- Invariant: mem_wr && mem_rd is never 1.
- Invariant: mem_wr and mem_rd are each high for at most one consecutive cycle.
- Non-strobed cycles: mem_wdata and the addresses hold their last values when the strobes are low.
- Boundary addresses: the swap is decided on the latched address. Address DEPTH/2-1 is not swapped; address DEPTH/2 is swapped.
- Reset mid-operation: an asynchronous rst_n assertion returns to IDLE immediately and clears strobes and rsp_valid. An in-flight read response is discarded.
- Memory reset: the memory's own reset is synchronous and is driven externally. The controller does not track memory contents.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> req_ready=1, busy=0, mem_wr=mem_rd=rsp_valid=0, rsp_rdata=0 without waiting for a clk edge.
- Lower-half round trip: write addr 1 data 2'b10, then read addr 1 with rsp_ready=1 -> mem_wdata=2'b10, memory holds 2'b10; rsp_valid 3 cycles after read accept with rsp_rdata=2'b10.
- Upper-half round trip: write addr 3 data 2'b10 -> memory holds 2'b01; read addr 3 -> mem_rdata=2'b01, rsp_rdata=2'b10.
- Boundary: write 2'b01 to addr 2 and 2'b01 to addr 1, then read both -> both reads return rsp_rdata=2'b01; memory word 2 holds 2'b10, word 1 holds 2'b01.
- Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; req_valid held high is not accepted until one cycle after the rsp_ready handshake.
- Reset during RESP and random stress: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately, state IDLE. Random traffic of 1000 requests -> mem_wr&&mem_rd never high, and every read returns the last value written to that address (post-reset reads return 0).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the single-port-pair memory: turns host valid/ready
// requests into one-cycle memory strobes and un-swaps upper-half read data.
module mem_access_ctrl #(
    parameter int WIDTH = 2,
    parameter int PSIZE = 2,
    parameter int DEPTH = 2**PSIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [PSIZE-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [PSIZE-1:0] mem_wr_addr,
    output logic [PSIZE-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    localparam logic [PSIZE-1:0] HALF = PSIZE'(DEPTH / 2);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PSIZE-1:0] addr_q;
    logic [PSIZE-1:0] addr_nxt;
    logic             accept;
    logic             upper;
    logic             mem_wr_nxt;
    logic             mem_rd_nxt;
    logic [WIDTH-1:0] mem_wdata_nxt;
    logic [PSIZE-1:0] mem_wr_addr_nxt;
    logic [PSIZE-1:0] mem_rd_addr_nxt;
    logic             rsp_valid_nxt;
    logic [WIDTH-1:0] rsp_rdata_nxt;

    assign accept = req_valid && (state == IDLE);
    // The swap decision uses the address latched at accept, not the live request bus.
    assign upper  = (addr_q >= HALF);

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wdata   <= '0;
            mem_wr_addr <= '0;
            mem_rd_addr <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nxt;
            addr_q      <= addr_nxt;
            mem_wr      <= mem_wr_nxt;
            mem_rd      <= mem_rd_nxt;
            mem_wdata   <= mem_wdata_nxt;
            mem_wr_addr <= mem_wr_addr_nxt;
            mem_rd_addr <= mem_rd_addr_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
        end
    end

    // Next-state decode.
    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise a path that leaves it unassigned infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = req_wr ? WR : RD;
            WR:   state_nxt = IDLE;
            RD:   state_nxt = CAP;
            CAP:  state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: strobes default low so each lasts exactly one cycle,
    // while data and addresses hold their last values between strobes.
    always_comb begin
        req_ready       = (state == IDLE);
        busy            = (state != IDLE);
        addr_nxt        = addr_q;
        mem_wr_nxt      = 1'b0;
        mem_rd_nxt      = 1'b0;
        mem_wdata_nxt   = mem_wdata;
        mem_wr_addr_nxt = mem_wr_addr;
        mem_rd_addr_nxt = mem_rd_addr;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    addr_nxt = req_addr;
                    if (req_wr) begin
                        mem_wr_nxt      = 1'b1;
                        mem_wr_addr_nxt = req_addr;
                        // Raw data: the memory swaps upper-half writes on its own.
                        mem_wdata_nxt   = req_wdata;
                    end else begin
                        mem_rd_nxt      = 1'b1;
                        mem_rd_addr_nxt = req_addr;
                    end
                end
            end
            CAP: begin
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = upper ? {mem_rdata[WIDTH/2-1:0], mem_rdata[WIDTH-1:WIDTH/2]}
                                      : mem_rdata;
            end
            RESP: begin
                if (rsp_ready) rsp_valid_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule
